// File: rtl/shift_sequencer.sv
// Multi-step shift controller: drives an external 1-bit shifter once per cycle for up to 15 steps.
// Optional carry-out of the final step is enabled with `define SHIFT_CARRY_EN.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] sh_a,
  output logic [4:0]       sh_op,
  output logic             sh_enable,
  input  logic [WIDTH-1:0] sh_out
`ifdef SHIFT_CARRY_EN
  ,
  output logic             carry
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [4:0] {
    OP_ROR = 5'b10000,
    OP_ROL = 5'b10001,
    OP_LSR = 5'b10010,
    OP_LSL = 5'b10011,
    OP_ASR = 5'b10100,
    OP_ASL = 5'b10101
  } shop_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             accept;
  logic             op_valid;
`ifdef SHIFT_CARRY_EN
  logic             carry_q, carry_d;
  logic             shift_right;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
`ifdef SHIFT_CARRY_EN
      carry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
`ifdef SHIFT_CARRY_EN
      carry_q  <= carry_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
`ifdef SHIFT_CARRY_EN
    carry_d     = carry_q;
    shift_right = (op_q == OP_ROR) || (op_q == OP_LSR) || (op_q == OP_ASR);
`endif
    op_valid = (op >= OP_ROR) && (op <= OP_ASL);
    accept   = start && (state_q != S_SHIFT);

    case (state_q)
      S_SHIFT: begin
        acc_d = sh_out;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        // cnt==0 cannot occur here; treating it as final guarantees exit from SHIFT
        if (cnt_q <= CNT_W'(1)) begin
          result_d = sh_out;
`ifdef SHIFT_CARRY_EN
          carry_d  = shift_right ? acc_q[0] : acc_q[WIDTH-1];
`endif
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      op_d  = op;
      acc_d = data_in;
      cnt_d = amount;
      if ((amount != '0) && op_valid) begin
        state_d = S_SHIFT;
      end else begin
        state_d  = S_DONE;
        result_d = data_in;
`ifdef SHIFT_CARRY_EN
        carry_d  = 1'b0;
`endif
      end
    end
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign sh_enable = (state_q == S_SHIFT);
  assign sh_a      = acc_q;
  assign sh_op     = op_q;
  assign result    = result_q;
`ifdef SHIFT_CARRY_EN
  assign carry     = carry_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer with a closed-form shift reference and cycle-level timing model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  op;
  logic [3:0]  amount;
  logic [15:0] data_in;
  logic        busy, done, sh_enable;
  logic [15:0] result, sh_a, sh_out;
  logic [4:0]  sh_op;
`ifdef SHIFT_CARRY_EN
  logic        carry;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .amount(amount),
    .data_in(data_in), .busy(busy), .done(done), .result(result),
    .sh_a(sh_a), .sh_op(sh_op), .sh_enable(sh_enable), .sh_out(sh_out)
`ifdef SHIFT_CARRY_EN
    , .carry(carry)
`endif
  );

  always #5 clk = ~clk;

  // External single-step shifter the sequencer drives.
  function automatic logic [15:0] step1(input logic [15:0] a, input logic [4:0] o);
    case (o)
      5'h10:        return {a[0], a[15:1]};
      5'h11:        return {a[14:0], a[15]};
      5'h12:        return {1'b0, a[15:1]};
      5'h13, 5'h15: return {a[14:0], 1'b0};
      5'h14:        return {a[15], a[15:1]};
      default:      return a;
    endcase
  endfunction

  always_comb sh_out = step1(sh_a, sh_op);

  function automatic logic is_valid(input logic [4:0] o);
    return (o >= 5'h10) && (o <= 5'h15);
  endfunction

  // Whole n-bit shift in one expression.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [4:0] o, input int n);
    logic [31:0] dd;
    logic [31:0] t;
    dd = {d, d};
    case (o)
      5'h10: begin t = dd >> n; return t[15:0]; end
      5'h11: begin t = dd << n; return t[31:16]; end
      5'h12: return d >> n;
      5'h13, 5'h15: return d << n;
      5'h14: return 16'($signed(d) >>> n);
      default: return d;
    endcase
  endfunction

  function automatic logic ref_carry(input logic [15:0] d, input logic [4:0] o, input int n);
    if (n == 0 || !is_valid(o)) return 1'b0;
    if (o == 5'h10 || o == 5'h12 || o == 5'h14) return d[n-1];
    return d[16-n];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  int          m_busy_left;
  logic        m_done;
  logic [15:0] m_result;
  logic        m_carry;
  logic [15:0] m_pend_result;
  logic        m_pend_carry;
  logic [15:0] m_data;
  logic [4:0]  m_op;
  int          m_steps;

  task automatic cycle(input logic rst, input logic st, input logic [4:0] o,
                       input logic [3:0] amt, input logic [15:0] d);
    logic was_busy;
    reset = rst; start = st; op = o; amount = amt; data_in = d;
    @(posedge clk);
    if (rst) begin
      m_busy_left = 0; m_done = 1'b0; m_result = '0; m_carry = 1'b0;
      m_data = '0; m_op = '0; m_steps = 0;
    end else begin
      was_busy = (m_busy_left > 0);
      m_done = 1'b0;
      if (was_busy) begin
        m_busy_left--;
        m_steps++;
        if (m_busy_left == 0) begin
          m_done = 1'b1; m_result = m_pend_result; m_carry = m_pend_carry;
        end
      end else if (st) begin
        m_data = d; m_op = o; m_steps = 0;
        if (amt != 0 && is_valid(o)) begin
          m_busy_left   = int'(amt);
          m_pend_result = ref_shift(d, o, int'(amt));
          m_pend_carry  = ref_carry(d, o, int'(amt));
        end else begin
          m_done = 1'b1; m_result = d; m_carry = 1'b0;
        end
      end
    end
    #1;
    check("busy",      32'(busy),      32'(m_busy_left > 0));
    check("done",      32'(done),      32'(m_done));
    check("sh_enable", 32'(sh_enable), 32'(m_busy_left > 0));
    check("result",    32'(result),    32'(m_result));
    check("sh_a",      32'(sh_a),      32'(ref_shift(m_data, m_op, m_steps)));
    check("sh_op",     32'(sh_op),     32'(m_op));
`ifdef SHIFT_CARRY_EN
    check("carry",     32'(carry),     32'(m_carry));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'h00, 4'd0, 16'h0000);
  endtask

  initial begin
    logic [4:0] rop;
    int r;
    cycle(1'b1, 1'b0, 5'h00, 4'd0, 16'h0000);
    cycle(1'b1, 1'b0, 5'h00, 4'd0, 16'h0000);
    check("reset_result", 32'(result), 32'h0);
    idle(1);

    // LSL 0x0001 by 4: busy four cycles, done in the fifth
    cycle(1'b0, 1'b1, 5'h13, 4'd4, 16'h0001);
    idle(4);
    check("lsl_done", 32'(done), 32'h1);
    check("lsl_result", 32'(result), 32'h0010);
    idle(1);

    cycle(1'b0, 1'b1, 5'h14, 4'd3, 16'h8000);
    idle(3);
    check("asr_result", 32'(result), 32'hF000);
    cycle(1'b0, 1'b1, 5'h10, 4'd1, 16'h0001);
    idle(1);
    check("ror_result", 32'(result), 32'h8000);
`ifdef SHIFT_CARRY_EN
    check("ror_carry", 32'(carry), 32'h1);
`endif
    idle(1);

    cycle(1'b0, 1'b1, 5'h12, 4'd0, 16'h1234);
    check("amt0_result", 32'(result), 32'h1234);
    idle(1);
    cycle(1'b0, 1'b1, 5'h1F, 4'd5, 16'hBEEF);
    check("badop_result", 32'(result), 32'hBEEF);
    check("badop_busy", 32'(busy), 32'h0);
    idle(2);

    // start mid-shift is ignored; start in the DONE cycle is accepted
    cycle(1'b0, 1'b1, 5'h13, 4'd3, 16'h0003);
    cycle(1'b0, 1'b1, 5'h12, 4'd2, 16'hFFFF);
    idle(2);
    check("ign_result", 32'(result), 32'h0018);
    cycle(1'b0, 1'b1, 5'h11, 4'd2, 16'hC000);
    idle(2);
    check("b2b_result", 32'(result), 32'h0003);
    idle(1);

    // reset during the second SHIFT cycle
    cycle(1'b0, 1'b1, 5'h13, 4'd8, 16'h00FF);
    idle(1);
    cycle(1'b1, 1'b0, 5'h00, 4'd0, 16'h0000);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    idle(10);

    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 7));
      rop = (r < 6) ? 5'(16 + r) : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 4), rop,
            4'($urandom_range(0, 15)), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
